// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of word stores draining into the data RAM write port, with load-overlap hazard detection.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic [31:0]              st_pc,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_addr,
  output logic                     ld_hazard,
  input  logic                     drain_en,
  output logic                     mem_write,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_data,
  output logic [31:0]              mem_pc,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0] addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [31:0] pc_q   [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic push, pop, hit;
  assign st_ready  = count_q < CW'(DEPTH);
  assign empty     = count_q == '0;
  assign count     = count_q;
  assign push      = st_valid && st_ready && !rst;
  assign pop       = !empty && drain_en && !rst;
  assign mem_write = pop;
  assign mem_addr  = empty ? '0 : addr_q[head_q];
  assign mem_data  = empty ? '0 : data_q[head_q];
  assign mem_pc    = empty ? '0 : pc_q[head_q];
  assign ld_hazard = ld_valid && hit;
  // The draining head stays in the compare; an entry being pushed is not yet valid.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      hit = hit | (valid_q[i] && addr_q[i][31:2] == ld_addr[31:2]);
  end
  always_comb begin
    head_d  = head_q + AW'(pop);
    tail_d  = tail_q + AW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
    valid_d = valid_q;
    if (push) valid_d[tail_q] = 1'b1;
    if (pop) valid_d[head_q] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
      pc_q[tail_q]   <= st_pc;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: table-driven directed vectors plus wrap and mid-queue reset sequences.
module tb_store_buffer;
  logic clk = 1'b0, rst = 1'b1;
  logic st_valid = 1'b0, ld_valid = 1'b0, drain_en = 1'b0;
  logic [31:0] st_addr = '0, st_data = '0, st_pc = '0, ld_addr = '0;
  logic st_ready, ld_hazard, mem_write, empty;
  logic [31:0] mem_addr, mem_data, mem_pc;
  logic [2:0] count;
  int total = 0, passed = 0;
  typedef struct {
    logic sv; logic [31:0] sa, sd, sp; logic de, lv; logic [31:0] la;
    logic rdy, mw; logic [31:0] ma, md, mp; logic hz; int cnt; logic emp;
  } vec_t;
  vec_t v[$];
  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_pc(st_pc), .st_ready(st_ready), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_hazard(ld_hazard), .drain_en(drain_en), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_pc(mem_pc), .empty(empty), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %h expected %h", n, a, e);
    else passed++;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t mk(input logic sv, input logic [31:0] sa, sd, sp, input logic de, lv,
                              input logic [31:0] la, input logic rdy, mw, input logic [31:0] ma, md, mp,
                              input logic hz, input int cnt, input logic emp);
    vec_t r;
    r.sv = sv; r.sa = sa; r.sd = sd; r.sp = sp; r.de = de; r.lv = lv; r.la = la;
    r.rdy = rdy; r.mw = mw; r.ma = ma; r.md = md; r.mp = mp; r.hz = hz; r.cnt = cnt; r.emp = emp;
    return r;
  endfunction
  initial begin
    // single store, then fill/stall/drain
    v.push_back(mk(1, 'h10, 'hDEADBEEF, 'h3000, 1, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 1, 0, 0,                    1, 1, 'h10, 'hDEADBEEF, 'h3000, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0,                    1, 0, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(1, 'h0, 'hA0, 'h100, 0, 0, 0,           1, 0, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(1, 'h4, 'hA1, 'h104, 0, 0, 0,           1, 0, 0, 'hA0, 'h100, 0, 1, 0));
    v.push_back(mk(1, 'h8, 'hA2, 'h108, 0, 0, 0,           1, 0, 0, 'hA0, 'h100, 0, 2, 0));
    v.push_back(mk(1, 'hC, 'hA3, 'h10C, 0, 0, 0,           1, 0, 0, 'hA0, 'h100, 0, 3, 0));
    v.push_back(mk(1, 'h50, 'hA4, 'h110, 0, 0, 0,          0, 0, 0, 'hA0, 'h100, 0, 4, 0));
    v.push_back(mk(1, 'h50, 'hA4, 'h110, 1, 0, 0,          0, 1, 0, 'hA0, 'h100, 0, 4, 0));
    v.push_back(mk(1, 'h50, 'hA4, 'h110, 1, 0, 0,          1, 1, 'h4, 'hA1, 'h104, 0, 3, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 0, 0,                    1, 1, 'h8, 'hA2, 'h108, 0, 3, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 0, 0,                    1, 1, 'hC, 'hA3, 'h10C, 0, 2, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 0, 0,                    1, 1, 'h50, 'hA4, 'h110, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0,                    1, 0, 0, 0, 0, 0, 0, 1));
    // load hazards around a store at 0x20
    v.push_back(mk(1, 'h20, 'h55, 'h200, 0, 1, 'h20,       1, 0, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 'h22,                 1, 0, 'h20, 'h55, 'h200, 1, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 'h24,                 1, 0, 'h20, 'h55, 'h200, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 'h20,                 1, 0, 'h20, 'h55, 'h200, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 1, 'h20,                 1, 1, 'h20, 'h55, 'h200, 1, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 'h20,                 1, 0, 0, 0, 0, 0, 0, 1));
    // same-address stores stay separate and ordered
    v.push_back(mk(1, 'h40, 'h1111, 'h300, 0, 0, 0,       1, 0, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(1, 'h40, 'h2222, 'h304, 0, 1, 'h43,    1, 0, 'h40, 'h1111, 'h300, 1, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 0, 0,                    1, 1, 'h40, 'h1111, 'h300, 0, 2, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 0, 0,                    1, 1, 'h40, 'h2222, 'h304, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 0, 0,                    1, 0, 0, 0, 0, 0, 0, 1));
    rst = 1'b1;
    drain_en = 1'b1;
    tick();
    chk("rst_mw", {31'b0, mem_write}, 0);
    tick();
    rst = 1'b0;
    drain_en = 1'b0;
    ld_valid = 1'b1;
    ld_addr = 32'h10;
    #1;
    chk("por_rdy", {31'b0, st_ready}, 1);
    chk("por_empty", {31'b0, empty}, 1);
    chk("por_count", {29'b0, count}, 0);
    chk("por_hz", {31'b0, ld_hazard}, 0);
    chk("por_maddr", mem_addr, 0);
    ld_valid = 1'b0;
    tick();
    for (int i = 0; i < v.size(); i++) begin
      st_valid = v[i].sv; st_addr = v[i].sa; st_data = v[i].sd; st_pc = v[i].sp;
      drain_en = v[i].de; ld_valid = v[i].lv; ld_addr = v[i].la;
      #1;
      chk($sformatf("r%0d st_ready", i), {31'b0, st_ready}, {31'b0, v[i].rdy});
      chk($sformatf("r%0d mem_write", i), {31'b0, mem_write}, {31'b0, v[i].mw});
      chk($sformatf("r%0d mem_addr", i), mem_addr, v[i].ma);
      chk($sformatf("r%0d mem_data", i), mem_data, v[i].md);
      chk($sformatf("r%0d mem_pc", i), mem_pc, v[i].mp);
      chk($sformatf("r%0d ld_hazard", i), {31'b0, ld_hazard}, {31'b0, v[i].hz});
      chk($sformatf("r%0d count", i), {29'b0, count}, v[i].cnt);
      chk($sformatf("r%0d empty", i), {31'b0, empty}, {31'b0, v[i].emp});
      tick();
    end
    st_valid = 1'b0; ld_valid = 1'b0;
    // ten stores streamed through with continuous draining; pointers wrap twice
    for (int k = 0; k <= 10; k++) begin
      st_valid = k < 10;
      st_addr = 4 * k;
      st_data = 32'hC0DE_0000 | k;
      st_pc = 32'h400 + 4 * k;
      drain_en = 1'b1;
      #1;
      chk($sformatf("w%0d mem_write", k), {31'b0, mem_write}, k > 0);
      chk($sformatf("w%0d count", k), {29'b0, count}, k > 0);
      if (k > 0) begin
        chk($sformatf("w%0d mem_addr", k), mem_addr, 4 * (k - 1));
        chk($sformatf("w%0d mem_data", k), mem_data, 32'hC0DE_0000 | (k - 1));
        chk($sformatf("w%0d mem_pc", k), mem_pc, 32'h400 + 4 * (k - 1));
      end
      tick();
    end
    st_valid = 1'b0;
    #1;
    chk("w_end empty", {31'b0, empty}, 1);
    tick();
    // reset with three stores pending
    drain_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      st_valid = 1'b1;
      st_addr = 32'h60 + 4 * k;
      st_data = 32'hBAD0_0000 | k;
      st_pc = 32'h500 + 4 * k;
      tick();
    end
    st_valid = 1'b0;
    #1;
    chk("rm count3", {29'b0, count}, 3);
    rst = 1'b1;
    drain_en = 1'b1;
    st_valid = 1'b1;
    st_addr = 32'h70;
    st_data = 32'hBAD0_00FF;
    #1;
    chk("rm mw_in_rst", {31'b0, mem_write}, 0);
    tick();
    rst = 1'b0;
    st_valid = 1'b0;
    ld_valid = 1'b1;
    ld_addr = 32'h60;
    #1;
    chk("rm count", {29'b0, count}, 0);
    chk("rm empty", {31'b0, empty}, 1);
    chk("rm rdy", {31'b0, st_ready}, 1);
    chk("rm mem_addr", mem_addr, 0);
    chk("rm mem_data", mem_data, 0);
    chk("rm mem_pc", mem_pc, 0);
    chk("rm hz60", {31'b0, ld_hazard}, 0);
    ld_addr = 32'h70;
    #1;
    chk("rm hz70", {31'b0, ld_hazard}, 0);
    ld_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rm drain%0d mem_write", k), {31'b0, mem_write}, 0);
      tick();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
